// File: rtl/shift_reg_pkg.sv
// Shared encodings and default sizing for the shift-register stream transmitter.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam int DEFAULT_DATA_WIDTH   = 4;
  localparam int DEFAULT_CLK_DIV_BITS = 3;

endpackage

// File: rtl/shift_reg_stream_tx_phase_timer.sv
// Phase divider: counts 0..2**CLK_DIV_BITS-1 and flags the last cycle of each phase.
module phase_timer #(
  parameter int CLK_DIV_BITS = 3
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  output logic o_phase_end
);

  localparam int CW = (CLK_DIV_BITS == 0) ? 1 : CLK_DIV_BITS;
  localparam logic [CW-1:0] LAST = CW'((2 ** CLK_DIV_BITS) - 1);

  logic [CW-1:0] count_q, count_d;

  assign o_phase_end = (count_q == LAST);

  always_comb begin
    count_d = count_q + CW'(1);
    if (i_clear || o_phase_end) count_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule

// File: rtl/shift_reg_stream_tx.sv
// Serializer: accepts one word per ready/valid handshake, shifts it MSB first, then latches it.
// Optional SHIFT_REG_OE_EN adds o_output_enable_n, kept blank until the first latch completes.
module shift_reg_stream_tx
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV_BITS = DEFAULT_CLK_DIV_BITS
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [(2**DATA_WIDTH)-1:0]  i_value,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_data_val,
  output logic                        o_data_clock,
  output logic                        o_latch_shifted_value,
`ifdef SHIFT_REG_OE_EN
  output logic                        o_busy,
  output logic                        o_output_enable_n
`else
  output logic                        o_busy
`endif
);

  // state    | meaning
  // ST_IDLE  | ready for a word, chain pins idle
  // ST_SETUP | current MSB driven on DS, SHCP low
  // ST_HIGH  | SHCP high, DS held; shift at phase end
  // ST_LATCH | STCP pulse high for one phase

  localparam int N = 2 ** DATA_WIDTH;

  state_e                state_q, state_d;
  logic [N-1:0]          shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] bitcnt_q, bitcnt_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  data_val_q, data_val_d;
  logic                  data_clock_q, data_clock_d;
  logic                  latch_q, latch_d;
  logic                  phase_end;
  logic                  timer_clear;

  assign timer_clear = (state_d != state_q);

  phase_timer #(.CLK_DIV_BITS(CLK_DIV_BITS)) u_phase_timer (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (timer_clear),
    .o_phase_end (phase_end)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          shreg_d  = i_value;
          bitcnt_d = '1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: if (phase_end) state_d = ST_HIGH;
      ST_HIGH: begin
        if (phase_end) begin
          shreg_d = {shreg_q[N-2:0], 1'b0};
          if (bitcnt_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            bitcnt_d = bitcnt_q - DATA_WIDTH'(1);
            state_d  = ST_SETUP;
          end
        end
      end
      ST_LATCH: if (phase_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so pins change on the same edge as the FSM.
    ready_d      = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    data_clock_d = (state_d == ST_HIGH);
    latch_d      = (state_d == ST_LATCH);
    data_val_d   = ((state_d == ST_SETUP) || (state_d == ST_HIGH)) ? shreg_d[N-1] : 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      data_val_q   <= 1'b0;
      data_clock_q <= 1'b0;
      latch_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      data_val_q   <= data_val_d;
      data_clock_q <= data_clock_d;
      latch_q      <= latch_d;
    end
  end

  assign o_ready               = ready_q;
  assign o_busy                = busy_q;
  assign o_data_val            = data_val_q;
  assign o_data_clock          = data_clock_q;
  assign o_latch_shifted_value = latch_q;

`ifdef SHIFT_REG_OE_EN
  logic oe_n_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                     oe_n_q <= 1'b1;
    else if (state_q == ST_LATCH && state_d == ST_IDLE) oe_n_q <= 1'b0;
  end

  assign o_output_enable_n = oe_n_q;
`endif

endmodule

// File: tb/tb_shift_reg_stream_tx.sv
// Directed bench for shift_reg_stream_tx: default divider instance plus a CLK_DIV_BITS=0 instance.
module tb_shift_reg_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_a = '0, value_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ready_a, dval_a, dclk_a, latch_a, busy_a;
  logic        ready_b, dval_b, dclk_b, latch_b, busy_b;
`ifdef SHIFT_REG_OE_EN
  logic        oe_a, oe_b;
`endif
  logic        sel = 1'b0;
  logic        mon_ready, mon_dval, mon_dclk, mon_latch, mon_busy;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  shift_reg_stream_tx #(.DATA_WIDTH(4), .CLK_DIV_BITS(3)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_value(value_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_data_val(dval_a), .o_data_clock(dclk_a),
    .o_latch_shifted_value(latch_a),
`ifdef SHIFT_REG_OE_EN
    .o_busy(busy_a), .o_output_enable_n(oe_a)
`else
    .o_busy(busy_a)
`endif
  );

  shift_reg_stream_tx #(.DATA_WIDTH(4), .CLK_DIV_BITS(0)) dut_div0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_value(value_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_data_val(dval_b), .o_data_clock(dclk_b),
    .o_latch_shifted_value(latch_b),
`ifdef SHIFT_REG_OE_EN
    .o_busy(busy_b), .o_output_enable_n(oe_b)
`else
    .o_busy(busy_b)
`endif
  );

  always_comb begin
    mon_ready = sel ? ready_b : ready_a;
    mon_dval  = sel ? dval_b  : dval_a;
    mon_dclk  = sel ? dclk_b  : dclk_a;
    mon_latch = sel ? latch_b : latch_a;
    mon_busy  = sel ? busy_b  : busy_a;
  end

  // Sample s is taken at the falling edge following accept edge + s. ready_cyc is the
  // distance from the accept edge to the next edge at which a new word can be accepted.
  task automatic run_frame(input logic use_b, input logic [15:0] word,
                           output logic [15:0] bits, output int n_rise, output int n_latch,
                           output int latch_w, output int falls_at_latch, output int ready_cyc,
                           output logic first_dv, output logic ready_s0, output logic timed_out);
    int   s, n_fall;
    logic prev_dclk, prev_dval, prev_latch, done;
    sel = use_b;
    bits = '0; n_rise = 0; n_latch = 0; latch_w = 0; falls_at_latch = -1; ready_cyc = -1;
    first_dv = 1'b0; ready_s0 = 1'b1; n_fall = 0; s = 0; done = 1'b0;
    prev_dclk = 1'b0; prev_dval = 1'b0; prev_latch = 1'b0;
    @(negedge clk);
    if (use_b) begin value_b = word; valid_b = 1'b1; end
    else       begin value_a = word; valid_a = 1'b1; end
    while (!done && s < 2000) begin
      @(negedge clk);
      if (s == 0) begin
        valid_a = 1'b0; valid_b = 1'b0;
        first_dv = mon_dval; ready_s0 = mon_ready;
      end
      if (mon_dclk && !prev_dclk) begin n_rise++; bits = {bits[14:0], prev_dval}; end
      if (!mon_dclk && prev_dclk) n_fall++;
      if (mon_latch && !prev_latch) begin
        n_latch++;
        if (n_latch == 1) falls_at_latch = n_fall;
      end
      if (mon_latch) latch_w++;
      if (mon_ready && s > 0) begin ready_cyc = s + 1; done = 1'b1; end
      prev_dclk = mon_dclk; prev_dval = mon_dval; prev_latch = mon_latch;
      s++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
    n_checks++; if (dclk_a !== 1'b0) $display("FAIL reset_dclk got %b want 0", dclk_a); else n_pass++;
    n_checks++; if (dval_a !== 1'b0) $display("FAIL reset_dval got %b want 0", dval_a); else n_pass++;
    n_checks++; if (latch_a !== 1'b0) $display("FAIL reset_latch got %b want 0", latch_a); else n_pass++;
    n_checks++; if (ready_b !== 1'b1) $display("FAIL reset_ready_div0 got %b want 1", ready_b); else n_pass++;
  endtask

  task automatic test_single_word();
    logic [15:0] bits;
    int          n_rise, n_latch, latch_w, falls_at, ready_cyc;
    logic        first_dv, ready_s0, to;
    run_frame(1'b0, 16'hA5C3, bits, n_rise, n_latch, latch_w, falls_at, ready_cyc, first_dv, ready_s0, to);
    n_checks++; if (to !== 1'b0) $display("FAIL single_timeout ready never returned"); else n_pass++;
    n_checks++; if (bits !== 16'hA5C3) $display("FAIL single_bits got %h want a5c3", bits); else n_pass++;
    n_checks++; if (n_rise != 16) $display("FAIL single_rises got %0d want 16", n_rise); else n_pass++;
    n_checks++; if (n_latch != 1) $display("FAIL single_latch_pulses got %0d want 1", n_latch); else n_pass++;
    n_checks++; if (latch_w != 8) $display("FAIL single_latch_width got %0d want 8", latch_w); else n_pass++;
    n_checks++; if (falls_at != 16) $display("FAIL single_latch_after_falls got %0d want 16", falls_at); else n_pass++;
    n_checks++; if (ready_cyc != 265) $display("FAIL single_ready_cycles got %0d want 265", ready_cyc); else n_pass++;
    n_checks++; if (first_dv !== 1'b1) $display("FAIL single_first_dval got %b want 1", first_dv); else n_pass++;
    n_checks++; if (ready_s0 !== 1'b0) $display("FAIL single_ready_drop got %b want 0", ready_s0); else n_pass++;
  endtask

  task automatic test_clkdiv0();
    logic [15:0] bits;
    int          n_rise, n_latch, latch_w, falls_at, ready_cyc;
    logic        first_dv, ready_s0, to;
    run_frame(1'b1, 16'hFFFF, bits, n_rise, n_latch, latch_w, falls_at, ready_cyc, first_dv, ready_s0, to);
    n_checks++; if (to !== 1'b0) $display("FAIL div0_timeout ready never returned"); else n_pass++;
    n_checks++; if (bits !== 16'hFFFF) $display("FAIL div0_bits got %h want ffff", bits); else n_pass++;
    n_checks++; if (n_rise != 16) $display("FAIL div0_rises got %0d want 16", n_rise); else n_pass++;
    n_checks++; if (latch_w != 1) $display("FAIL div0_latch_width got %0d want 1", latch_w); else n_pass++;
    n_checks++; if (n_latch != 1) $display("FAIL div0_latch_pulses got %0d want 1", n_latch); else n_pass++;
    n_checks++; if (ready_cyc != 34) $display("FAIL div0_ready_cycles got %0d want 34", ready_cyc); else n_pass++;
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          s, n_rise, n_latch, accept2_s, ready_hi;
    logic [31:0] bits;
    logic        prev_dclk, prev_dval, prev_latch, prev_ready, done;
    sel = 1'b0;
    s = 0; n_rise = 0; n_latch = 0; accept2_s = -1; ready_hi = 0; bits = '0; done = 1'b0;
    prev_dclk = 1'b0; prev_dval = 1'b0; prev_latch = 1'b0; prev_ready = 1'b1;
    @(negedge clk);
    value_a = 16'h0001; valid_a = 1'b1;
    while (!done && s < 2000) begin
      @(negedge clk);
      if (s == 0) value_a = 16'hFFFF;
      if (s == 100) value_a = 16'h8000;
      if (prev_ready && !mon_ready && s > 0) begin accept2_s = s; valid_a = 1'b0; end
      if (mon_ready && accept2_s < 0) ready_hi++;
      if (mon_dclk && !prev_dclk) begin n_rise++; bits = {bits[30:0], prev_dval}; end
      if (mon_latch && !prev_latch) n_latch++;
      if (mon_ready && accept2_s > 0) done = 1'b1;
      prev_ready = mon_ready; prev_dclk = mon_dclk; prev_dval = mon_dval; prev_latch = mon_latch;
      s++;
    end
    valid_a = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL b2b_timeout second frame never finished"); else n_pass++;
    n_checks++; if (accept2_s != 265) $display("FAIL b2b_second_accept got %0d want 265", accept2_s); else n_pass++;
    n_checks++; if (ready_hi != 1) $display("FAIL b2b_idle_cycles got %0d want 1", ready_hi); else n_pass++;
    n_checks++; if (n_rise != 32) $display("FAIL b2b_rises got %0d want 32", n_rise); else n_pass++;
    n_checks++; if (bits !== 32'h0001_8000) $display("FAIL b2b_bits got %h want 00018000", bits); else n_pass++;
    n_checks++; if (n_latch != 2) $display("FAIL b2b_latch_pulses got %0d want 2", n_latch); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int          s, n_rise, latch_seen;
    logic        prev_dclk;
    logic [15:0] bits;
    int          n_rise2, n_latch2, latch_w2, falls_at2, ready_cyc2;
    logic        first_dv2, ready_s02, to2;
    sel = 1'b0;
    s = 0; n_rise = 0; latch_seen = 0; prev_dclk = 1'b0;
    @(negedge clk);
    value_a = 16'hFFFF; valid_a = 1'b1;
    while (n_rise < 7 && s < 2000) begin
      @(negedge clk);
      if (s == 0) valid_a = 1'b0;
      if (dclk_a && !prev_dclk) n_rise++;
      if (latch_a) latch_seen++;
      prev_dclk = dclk_a;
      s++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (n_rise != 7) $display("FAIL mid_reach_7th_rise got %0d want 7", n_rise); else n_pass++;
    n_checks++; if (dclk_a !== 1'b0) $display("FAIL mid_dclk got %b want 0", dclk_a); else n_pass++;
    n_checks++; if (dval_a !== 1'b0) $display("FAIL mid_dval got %b want 0", dval_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL mid_busy got %b want 0", busy_a); else n_pass++;
    n_checks++; if (ready_a !== 1'b1) $display("FAIL mid_ready got %b want 1", ready_a); else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (latch_a) latch_seen++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (latch_a) latch_seen++;
    end
    n_checks++; if (latch_seen != 0) $display("FAIL mid_no_latch got %0d want 0", latch_seen); else n_pass++;
    run_frame(1'b0, 16'h1234, bits, n_rise2, n_latch2, latch_w2, falls_at2, ready_cyc2, first_dv2, ready_s02, to2);
    n_checks++; if (bits !== 16'h1234) $display("FAIL mid_next_bits got %h want 1234", bits); else n_pass++;
    n_checks++; if (n_latch2 != 1) $display("FAIL mid_next_latch got %0d want 1", n_latch2); else n_pass++;
    n_checks++; if (ready_cyc2 != 265) $display("FAIL mid_next_ready got %0d want 265", ready_cyc2); else n_pass++;
  endtask

`ifdef SHIFT_REG_OE_EN
  task automatic test_output_enable();
    int   s, oe_hi, oe_low_s, oe_hi2;
    logic done;
    n_checks++; if (oe_a !== 1'b1) $display("FAIL oe_after_reset got %b want 1", oe_a); else n_pass++;
    s = 0; oe_hi = 0; oe_low_s = -1; done = 1'b0;
    @(negedge clk);
    value_a = 16'h0F0F; valid_a = 1'b1;
    while (!done && s < 2000) begin
      @(negedge clk);
      if (s == 0) valid_a = 1'b0;
      if (oe_a) oe_hi++;
      else if (oe_low_s < 0) oe_low_s = s;
      if (ready_a && s > 0) done = 1'b1;
      s++;
    end
    n_checks++; if (oe_low_s != 264) $display("FAIL oe_fall_sample got %0d want 264", oe_low_s); else n_pass++;
    n_checks++; if (oe_hi != 264) $display("FAIL oe_blank_samples got %0d want 264", oe_hi); else n_pass++;
    s = 0; oe_hi2 = 0; done = 1'b0;
    @(negedge clk);
    value_a = 16'hF0F0; valid_a = 1'b1;
    while (!done && s < 2000) begin
      @(negedge clk);
      if (s == 0) valid_a = 1'b0;
      if (oe_a) oe_hi2++;
      if (ready_a && s > 0) done = 1'b1;
      s++;
    end
    n_checks++; if (oe_hi2 != 0) $display("FAIL oe_second_frame got %0d want 0", oe_hi2); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef SHIFT_REG_OE_EN
    test_output_enable();
`endif
    test_single_word();
    test_clkdiv0();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
